// File: rtl/fsb_tx_arbiter.sv
// fsb_tx_arbiter
//   Arbitrates NUM_REQ packet requesters onto a single registered FSB write
//   channel. Round-robin priority with burst locking: a grantee may keep the
//   channel for up to BURST_MAX consecutive packets while others wait. The
//   single output entry can be replaced in the same cycle it is consumed, so
//   the channel sustains one packet per cycle.
//
// Ports
//   clk, pipe_rst_n   clock (rising edge), async active-low reset
//   en_i              permits new packets to be accepted
//   req_v_i           per-requester packet valid
//   req_data_i        packets, requester i at [i*FSB_WIDTH +: FSB_WIDTH]
//   req_yumi_o        one-hot-or-zero: requester's packet taken this cycle
//   fsb_wvalid_o      registered packet valid toward the FSB adapter
//   fsb_wdata_o       registered packet
//   fsb_yumi_i        downstream consumed the presented packet
//   grant_id_o        requester index of the packet in the output register
//   pkt_cnt_o         per-requester accepted-packet counters (16 bit, wrap)
module fsb_tx_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int FSB_WIDTH = 80,
    parameter int BURST_MAX = 4
) (
    input  logic                      clk,
    input  logic                      pipe_rst_n,
    input  logic                      en_i,
    input  logic [NUM_REQ-1:0]        req_v_i,
    input  logic [NUM_REQ*FSB_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_yumi_o,
    output logic                      fsb_wvalid_o,
    output logic [FSB_WIDTH-1:0]      fsb_wdata_o,
    input  logic                      fsb_yumi_i,
    output logic [2:0]                grant_id_o,
    output logic [NUM_REQ*16-1:0]     pkt_cnt_o
);

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX - 1);

    logic                          out_v_q, out_v_d;
    logic [FSB_WIDTH-1:0]          out_data_q, out_data_d;
    logic [2:0]                    out_id_q, out_id_d;
    logic [2:0]                    last_q, last_d;
    logic                          locked_q, locked_d;
    logic [3:0]                    burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0][15:0]      pkt_cnt_q, pkt_cnt_d;

    // Valid vector widened to 8 so a 3-bit index is always in range.
    logic [7:0]           req_pad;
    logic [2:0]           win;
    logic                 found;
    logic                 load;
    logic [3:0]           idx;
    logic [FSB_WIDTH-1:0] win_data;

    assign req_pad = 8'(req_v_i);

    // Winner: stay on the locked grantee while its burst budget lasts,
    // otherwise scan round-robin starting just after the last grantee. The
    // scan ends on the last grantee itself, so a lone requester keeps going.
    always_comb begin
        win   = last_q;
        found = 1'b0;
        idx   = 4'd0;
        if (locked_q && req_pad[last_q] && (burst_cnt_q < BURST_LIM)) begin
            found = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = 4'(last_q) + 4'(k);
                if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
                if (!found && req_pad[idx[2:0]]) begin
                    found = 1'b1;
                    win   = idx[2:0];
                end
            end
        end
    end

    // Gated by reset so no requester sees a consume while reset is held.
    assign load = pipe_rst_n & en_i & found & (~out_v_q | fsb_yumi_i);

    // Only the winner's slice is muxed, so X on losing requesters' data
    // cannot reach the output register.
    always_comb begin
        win_data   = '0;
        req_yumi_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == 3'(i)) win_data = req_data_i[i*FSB_WIDTH +: FSB_WIDTH];
            req_yumi_o[i] = load && (win == 3'(i));
        end
    end

    always_comb begin
        out_v_d     = out_v_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        last_d      = last_q;
        locked_d    = locked_q;
        burst_cnt_d = burst_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        if (load) begin
            out_v_d    = 1'b1;
            out_data_d = win_data;
            out_id_d   = win;
            last_d     = win;
            locked_d   = 1'b1;
            // Saturates at the limit: any value at or above it already
            // forces a round-robin scan, so counting further changes nothing.
            if (win == last_q && locked_q)
                burst_cnt_d = (burst_cnt_q < BURST_LIM) ? burst_cnt_q + 4'd1 : burst_cnt_q;
            else
                burst_cnt_d = 4'd0;
            for (int i = 0; i < NUM_REQ; i++)
                if (win == 3'(i)) pkt_cnt_d[i] = pkt_cnt_q[i] + 16'd1;
        end else begin
            if (fsb_yumi_i) out_v_d = 1'b0;
            // An idle grantee gives up its burst; with en_i low the
            // arbitration state is frozen.
            if (en_i && !req_pad[last_q]) locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            out_v_q     <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 3'd0;
            last_q      <= 3'(NUM_REQ - 1);
            locked_q    <= 1'b0;
            burst_cnt_q <= 4'd0;
            pkt_cnt_q   <= '0;
        end else begin
            out_v_q     <= out_v_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            last_q      <= last_d;
            locked_q    <= locked_d;
            burst_cnt_q <= burst_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign fsb_wvalid_o = out_v_q;
    assign fsb_wdata_o  = out_data_q;
    assign grant_id_o   = out_id_q;
    assign pkt_cnt_o    = pkt_cnt_q;

endmodule

// File: tb/tb_fsb_tx_arbiter.sv
// Bench for fsb_tx_arbiter: a NUM_REQ=3 / BURST_MAX=4 instance checked every
// cycle against a behavioural model, plus a BURST_MAX=1 instance for the
// strict round-robin case.
module tb_fsb_tx_arbiter;
    localparam int N  = 3;
    localparam int W  = 16;
    localparam int BM = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           yumi = 1'b0;
    logic [N-1:0]   rv = '0;
    logic [N*W-1:0] rd = '0;

    logic [N-1:0]    a_yumi, b_yumi;
    logic            a_wv, b_wv;
    logic [W-1:0]    a_wd, b_wd;
    logic [2:0]      a_gid, b_gid;
    logic [N*16-1:0] a_cnt, b_cnt;

    fsb_tx_arbiter #(.NUM_REQ(N), .FSB_WIDTH(W), .BURST_MAX(BM)) dut_a (
        .clk(clk), .pipe_rst_n(rst_n), .en_i(en), .req_v_i(rv), .req_data_i(rd),
        .req_yumi_o(a_yumi), .fsb_wvalid_o(a_wv), .fsb_wdata_o(a_wd),
        .fsb_yumi_i(yumi), .grant_id_o(a_gid), .pkt_cnt_o(a_cnt));

    fsb_tx_arbiter #(.NUM_REQ(N), .FSB_WIDTH(W), .BURST_MAX(1)) dut_b (
        .clk(clk), .pipe_rst_n(rst_n), .en_i(en), .req_v_i(rv), .req_data_i(rd),
        .req_yumi_o(b_yumi), .fsb_wvalid_o(b_wv), .fsb_wdata_o(b_wd),
        .fsb_yumi_i(yumi), .grant_id_o(b_gid), .pkt_cnt_o(b_cnt));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state (spec-level quantities, unbounded burst count).
    bit         m_v;
    logic [W-1:0] m_data;
    int         m_id, m_last, m_burst;
    bit         m_locked;
    int         m_cnt[N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_v = 0; m_data = '0; m_id = 0; m_last = N - 1; m_locked = 0; m_burst = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic drive(input logic [N-1:0] v, input bit e, input bit y);
        rv = v; en = e; yumi = y;
        for (int i = 0; i < N; i++)
            rd[i*W +: W] = v[i] ? W'($urandom) : {W{1'bx}};
    endtask

    // One clock: compare at negedge, advance model at posedge.
    task automatic cyc();
        int g;
        bit found, load;
        logic [N-1:0]    exp_yumi;
        logic [N*16-1:0] exp_cnt;
        @(negedge clk);
        found = 0;
        g = m_last;
        if (m_locked && rv[m_last] && m_burst < BM - 1) found = 1;
        else begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (!found && rv[j]) begin found = 1; g = j; end
            end
        end
        load = rst_n && en && found && (!m_v || yumi);
        exp_yumi = load ? (N'(1) << g) : '0;
        for (int i = 0; i < N; i++) exp_cnt[i*16 +: 16] = 16'(m_cnt[i]);
        chk("req_yumi", 64'(a_yumi), 64'(exp_yumi));
        chk("wvalid",   64'(a_wv),   64'(m_v));
        chk("wdata",    64'(a_wd),   64'(m_data));
        chk("grant_id", 64'(a_gid),  64'(m_id));
        chk("pkt_cnt",  64'(a_cnt),  64'(exp_cnt));
        @(posedge clk);
        if (load) begin
            m_burst  = (g == m_last && m_locked) ? m_burst + 1 : 0;
            m_v      = 1;
            m_data   = rd[g*W +: W];
            m_id     = g;
            m_cnt[g] = (m_cnt[g] + 1) % 65536;
            m_last   = g;
            m_locked = 1;
        end else begin
            if (yumi) m_v = 0;
            if (en && !rv[m_last]) m_locked = 0;
        end
        #1;
    endtask

    // Reset asserted mid-cycle; outputs must drop without waiting for a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_wvalid", 64'(a_wv), 64'd0);
        chk("rst_yumi",   64'(a_yumi), 64'd0);
        chk("rst_yumi_b", 64'(b_yumi), 64'd0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int exp30[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    logic [W-1:0] held;

    initial begin
        m_reset();
        drive('0, 0, 0);
        #1;
        do_reset();
        drive('0, 1, 0);
        cyc(); cyc();

        // Two requesters streaming with constant consume: bursts of four.
        for (int i = 0; i < 9; i++) begin
            drive(3'b011, 1, 1);
            cyc();
            chk("burst_gid", 64'(a_gid), 64'(exp30[i]));
            chk("burst_wv",  64'(a_wv),  64'd1);
        end

        // Downstream stalled: one consume, packet held stable.
        do_reset();
        drive(3'b010, 1, 0);
        cyc();
        held = a_wd;
        for (int i = 0; i < 4; i++) begin drive(3'b010, 1, 0); cyc(); end
        chk("hold_data", 64'(a_wd), 64'(held));
        for (int i = 0; i < 4; i++) begin drive(3'b010, 1, 1); cyc(); end

        // en_i dropped with a held packet: delivered, then channel idles.
        drive(3'b111, 1, 0); cyc();
        for (int i = 0; i < 3; i++) begin drive(3'b111, 0, 0); cyc(); end
        drive(3'b111, 0, 1); cyc();
        for (int i = 0; i < 3; i++) begin drive(3'b111, 0, 1); cyc(); end
        chk("en_off_wv", 64'(a_wv), 64'd0);
        drive(3'b111, 1, 1); cyc();

        // BURST_MAX=1 instance: strict round-robin.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(3'b111, 1, 1);
            cyc();
            chk("rr_gid", 64'(b_gid), 64'(i % 3));
        end
        chk("rr_cnt", 64'(b_cnt), 64'({16'd2, 16'd2, 16'd2}));

        // Reset in the middle of a burst (out_v=1, burst count 2).
        do_reset();
        for (int i = 0; i < 3; i++) begin drive(3'b001, 1, 1); cyc(); end
        drive(3'b111, 1, 1);
        do_reset();
        cyc();
        chk("post_rst_gid", 64'(a_gid), 64'd0);
        chk("post_rst_wv",  64'(a_wv),  64'd1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(N'($urandom), ($urandom % 8) != 0, ($urandom % 3) != 0);
            cyc();
        end

        // Counter wrap on requester 0.
        do_reset();
        for (int i = 0; i < 65536; i++) begin drive(3'b001, 1, 1); cyc(); end
        chk("wrap_cnt", 64'(a_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
